// File: rtl/uart_tx_fifo_drain_if.sv
// Fifo read port between a byte fifo and the UART transmitter that drains it.
//   read      : pop strobe from the consumer, one-cycle pulse per byte
//   empty     : fifo empty flag from the fifo
//   read_data : byte at the head of the fifo, valid the cycle after read=1
// master = consumer (the transmitter), slave = fifo.
interface uart_tx_fifo_drain_if;
   logic       read;
   logic       empty;
   logic [7:0] read_data;

   modport master (output read, input empty, input read_data);
   modport slave  (input read, output empty, output read_data);
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a byte fifo and sends each byte as 8N1/8N2,
// LSB first.
//   clk     : system clock, rising edge
//   reset   : asynchronous active-low reset
//   enable  : 1 = start new frames while the fifo holds data
//   fifo    : fifo read port (read / empty / read_data), master side
//   tx      : serial line, idle high
//   busy    : high whenever the FSM is not IDLE
//   tx_done : one-cycle pulse on the last cycle of the final stop bit
// All outputs are registered; each is assigned together with the state
// transition that makes it valid.
module uart_tx_fifo_drain #(
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   uart_tx_fifo_drain_if.master  fifo,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, STOP} state_t;

   state_t        state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_cnt;   // data bit index in DATA, stop bit index in STOP
   logic [7:0]    shift;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tx        <= 1'b1;
         fifo.read <= 1'b0;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
         baud      <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
      end else begin
         fifo.read <= 1'b0;
         tx_done   <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (enable && !fifo.empty) begin
                  state     <= POP;
                  fifo.read <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            POP: state <= LOAD;
            LOAD: begin
               // read_data is valid now, one cycle after the pop strobe
               shift <= fifo.read_data;
               baud  <= '0;
               tx    <= 1'b0;
               state <= START;
            end
            START: begin
               if (baud == BAUD_LAST) begin
                  baud    <= '0;
                  bit_cnt <= '0;
                  tx      <= shift[0];
                  state   <= DATA;
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            DATA: begin
               if (baud == BAUD_LAST) begin
                  baud <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     shift   <= shift >> 1;
                     tx      <= shift[1];
                  end
               end else begin
                  baud <= baud + BW'(1);
               end
            end
            STOP: begin
               if (baud == BAUD_LAST) begin
                  baud <= '0;
                  if (bit_cnt == STOP_LAST) begin
                     bit_cnt <= '0;
                     // enable/empty only matter here and in IDLE
                     if (enable && !fifo.empty) begin
                        state     <= POP;
                        fifo.read <= 1'b1;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                  end
               end else begin
                  baud <= baud + BW'(1);
                  // registered pulse: raise it one cycle early so it lands on the final cycle
                  if (bit_cnt == STOP_LAST && baud == BAUD_PRE)
                     tx_done <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with CLKS_PER_BIT=4. dut1 uses one
// stop bit and is fed by a small fifo model; dut2 uses two stop bits and is
// fed by hand.
module tb_uart_tx_fifo_drain;

   localparam int N = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic enable2 = 1'b0;
   logic tx1, busy1, done1;
   logic tx2, busy2, done2;

   int checks = 0;
   int failures = 0;
   int sel = 0;   // 0 = observe dut1, 1 = observe dut2

   always #5 clk = ~clk;

   uart_tx_fifo_drain_if fif ();
   uart_tx_fifo_drain_if fif2 ();

   uart_tx_fifo_drain #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .fifo(fif),
      .tx(tx1), .busy(busy1), .tx_done(done1));

   uart_tx_fifo_drain #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dut2 (
      .clk(clk), .reset(reset), .enable(enable2), .fifo(fif2),
      .tx(tx2), .busy(busy2), .tx_done(done2));

   // fifo model for dut1: wp advanced by stimulus, rp by pops
   logic [7:0] fmem [0:15];
   int wp = 0;
   int rp = 0;
   logic [7:0] rdata = 8'h00;
   assign fif.empty     = (wp == rp);
   assign fif.read_data = rdata;

   always @(posedge clk) begin
      if (fif.read && wp != rp) begin
         rdata <= fmem[rp % 16];
         rp    <= rp + 1;
      end
   end

   // dut2 source: one byte 8'h88, empty driven by the stimulus
   logic empty2 = 1'b1;
   assign fif2.empty     = empty2;
   assign fif2.read_data = 8'h88;

   wire tx_m   = sel ? tx2 : tx1;
   wire busy_m = sel ? busy2 : busy1;
   wire done_m = sel ? done2 : done1;
   wire read_m = sel ? fif2.read : fif.read;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      fmem[wp % 16] = b;
      wp = wp + 1;
   endtask

   task automatic wait_read(input string tag, input int budget);
      int n = 0;
      @(negedge clk);
      while (!read_m && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_read_seen"}, 32'(read_m), 1);
   endtask

   // Called at the negedge where read is high (POP); returns at the
   // negedge of the final stop cycle.
   task automatic frame(input string tag, input logic [7:0] b, input int sb);
      chk({tag, "_pop_busy"}, 32'(busy_m), 1);
      @(negedge clk);
      chk({tag, "_load_tx"}, 32'(tx_m), 1);
      chk({tag, "_load_read"}, 32'(read_m), 0);
      for (int i = 0; i < N; i++) begin
         @(negedge clk);
         chk({tag, "_start"}, 32'(tx_m), 0);
      end
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < N; i++) begin
            @(negedge clk);
            chk($sformatf("%s_bit%0d", tag, k), 32'(tx_m), 32'(b[k]));
            chk({tag, "_data_read"}, 32'(read_m), 0);
         end
      end
      for (int i = 0; i < sb * N; i++) begin
         @(negedge clk);
         chk($sformatf("%s_stop%0d", tag, i), 32'(tx_m), 1);
         chk($sformatf("%s_done%0d", tag, i), 32'(done_m), 32'(i == sb * N - 1));
         chk({tag, "_stop_busy"}, 32'(busy_m), 1);
      end
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, "_idle_busy"}, 32'(busy_m), 0);
      chk({tag, "_idle_read"}, 32'(read_m), 0);
      chk({tag, "_idle_tx"}, 32'(tx_m), 1);
      chk({tag, "_idle_done"}, 32'(done_m), 0);
   endtask

   initial begin
      // 1. reset held with data available
      push(8'h88);
      enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx1), 1);
         chk("rst_read", 32'(fif.read), 0);
         chk("rst_busy", 32'(busy1), 0);
         chk("rst_done", 32'(done1), 0);
      end
      reset = 1'b1;
      @(negedge clk);
      chk("rst_rel_read", 32'(fif.read), 1);

      // 2. single byte
      frame("single", 8'h88, 1);
      idle_check("single");

      // 3. back-to-back, read pulses 42 cycles apart
      push(8'h88);
      push(8'h33);
      wait_read("b2b", 10);
      frame("b2b_a", 8'h88, 1);
      @(negedge clk);
      chk("b2b_read2", 32'(fif.read), 1);
      chk("b2b_gap_tx", 32'(tx1), 1);
      frame("b2b_b", 8'h33, 1);
      idle_check("b2b");

      // 4. empty fifo
      begin
         logic any_read = 1'b0, any_low = 1'b0, any_busy = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            any_read |= fif.read;
            any_low  |= ~tx1;
            any_busy |= busy1;
         end
         chk("empty_read", 32'(any_read), 0);
         chk("empty_tx_low", 32'(any_low), 0);
         chk("empty_busy", 32'(any_busy), 0);
      end

      // 5. enable dropped mid-frame with a second byte queued
      push(8'hA5);
      push(8'h5A);
      wait_read("en", 10);
      fork
         frame("en_a5", 8'hA5, 1);
         begin
            repeat (12) @(negedge clk);
            enable = 1'b0;
         end
      join
      begin
         logic any_read = 1'b0;
         @(negedge clk);
         chk("en_off_busy", 32'(busy1), 0);
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any_read |= fif.read;
         end
         chk("en_off_read", 32'(any_read), 0);
      end
      enable = 1'b1;
      @(negedge clk);
      chk("en_on_read", 32'(fif.read), 1);
      frame("en_5a", 8'h5A, 1);
      idle_check("en");

      // 6. reset during bit 3 of 8'h0F
      push(8'h0F);
      wait_read("mrst", 10);
      repeat (1 + N + 3 * N + 2) @(negedge clk);
      chk("mrst_pre_busy", 32'(busy1), 1);
      #2 reset = 1'b0;
      #1;
      chk("mrst_tx", 32'(tx1), 1);
      chk("mrst_busy", 32'(busy1), 0);
      chk("mrst_read", 32'(fif.read), 0);
      @(negedge clk);
      reset = 1'b1;
      chk("mrst_fifo_empty", 32'(fif.empty), 1);
      begin
         logic any_busy = 1'b0, any_low = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            any_busy |= busy1;
            any_low  |= ~tx1;
         end
         chk("mrst_stay_idle", 32'(any_busy), 0);
         chk("mrst_tx_high", 32'(any_low), 0);
      end

      // 7. two stop bits (dut2)
      sel = 1;
      enable2 = 1'b1;
      empty2 = 1'b0;
      wait_read("sb2", 10);
      empty2 = 1'b1;
      frame("sb2", 8'h88, 2);
      idle_check("sb2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
